// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: forwarding selects, load-use/branch stalls, branch flush, mul/div hold.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush event counters.
module hazard_controller #(
    parameter int MD_LATENCY = 4  // legal range 2..15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic       id_branch,
    input  logic       pc_src,
    input  logic [3:0] ex_rd,
    input  logic [3:0] m_rd,
    input  logic [3:0] wb_rd,
    input  logic [1:0] ex_reg_write,
    input  logic [1:0] m_reg_write,
    input  logic [1:0] wb_reg_write,
    input  logic       ex_mem_read,
    input  logic       ex_muldiv,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       ctrl_flush,
    output logic       idex_write,
    output logic       exm_bubble,
    output logic [1:0] op1_fwd,
    output logic [1:0] op2_fwd,
    output logic [1:0] r0_fwd,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZARD_STATS_EN
   ,output logic [15:0] stall_count,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} md_state_t;

    localparam logic [3:0] CNT_INIT = 4'(MD_LATENCY - 2);

    md_state_t  state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       md_stall;
    logic       hz_stall;
    logic [1:0] op1_sel, op2_sel, r0_sel;

    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic m_hit, input logic wb_hit);
        if (ex_hit)      return 2'b01;
        else if (m_hit)  return 2'b10;
        else if (wb_hit) return 2'b11;
        else             return 2'b00;
    endfunction

    // A load in EX has no data yet, so it never forwards from EX; the load-use stall covers it.
    assign op1_sel = fwd_sel(ex_reg_write[0] && !ex_mem_read && ex_rd == id_rs1,
                             m_reg_write[0] && m_rd == id_rs1,
                             wb_reg_write[0] && wb_rd == id_rs1);
    assign op2_sel = fwd_sel(ex_reg_write[0] && !ex_mem_read && ex_rd == id_rs2,
                             m_reg_write[0] && m_rd == id_rs2,
                             wb_reg_write[0] && wb_rd == id_rs2);
    assign r0_sel  = fwd_sel(ex_reg_write[1] || (ex_reg_write[0] && ex_rd == 4'd0),
                             m_reg_write[1]  || (m_reg_write[0]  && m_rd  == 4'd0),
                             wb_reg_write[1] || (wb_reg_write[0] && wb_rd == 4'd0));

    // The branch comparator reads unforwarded rd1, so any in-flight EX write to rs1 must settle first.
    assign hz_stall = (ex_mem_read && ex_reg_write[0] &&
                       (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2))) ||
                      (id_branch && ex_reg_write[0] && ex_rd == id_rs1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        md_stall  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ex_muldiv) begin
                    md_stall = 1'b1;
                    if (MD_LATENCY == 2) begin
                        state_nxt = RELEASE;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                md_stall = 1'b1;
                if (cnt == 4'd1) state_nxt = RELEASE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            // Instruction leaves EX this cycle; ex_muldiv still reflects it, so ignore it.
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        idex_write = 1'b1;
        ifid_flush = 1'b0;
        ctrl_flush = 1'b0;
        exm_bubble = 1'b0;
        md_busy    = 1'b0;
        md_done    = 1'b0;
        op1_fwd    = 2'b00;
        op2_fwd    = 2'b00;
        r0_fwd     = 2'b00;
        if (reset_n) begin
            op1_fwd = op1_sel;
            op2_fwd = op2_sel;
            r0_fwd  = r0_sel;
            md_done = (state == RELEASE);
            if (md_stall) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_write = 1'b0;
                exm_bubble = 1'b1;
                md_busy    = 1'b1;
            end else if (hz_stall) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ctrl_flush = 1'b1;
            end else if (pc_src) begin
                ifid_flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            if (!pc_write && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
            if (ifid_flush && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] id_rs1, id_rs2, ex_rd, m_rd, wb_rd;
    logic       id_uses_rs2, id_branch, pc_src, ex_mem_read, ex_muldiv;
    logic [1:0] ex_reg_write, m_reg_write, wb_reg_write;
    logic       pc_write, ifid_write, ifid_flush, ctrl_flush, idex_write, exm_bubble;
    logic [1:0] op1_fwd, op2_fwd, r0_fwd;
    logic       md_busy, md_done;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count, flush_count;
`endif

    hazard_controller #(.MD_LATENCY(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .id_branch(id_branch),
        .pc_src(pc_src), .ex_rd(ex_rd), .m_rd(m_rd), .wb_rd(wb_rd),
        .ex_reg_write(ex_reg_write), .m_reg_write(m_reg_write), .wb_reg_write(wb_reg_write),
        .ex_mem_read(ex_mem_read), .ex_muldiv(ex_muldiv),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .ctrl_flush(ctrl_flush), .idex_write(idex_write), .exm_bubble(exm_bubble),
        .op1_fwd(op1_fwd), .op2_fwd(op2_fwd), .r0_fwd(r0_fwd),
        .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_STATS_EN
       ,.stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    // ctl = {pc_write, ifid_write, ifid_flush, ctrl_flush, idex_write, exm_bubble, md_busy, md_done}
    localparam logic [7:0] NORM = 8'b1100_1000;
    localparam logic [7:0] HZ   = 8'b0001_1000;
    localparam logic [7:0] FLSH = 8'b1110_1000;
    localparam logic [7:0] MD   = 8'b0000_0110;
    localparam logic [7:0] DONE = 8'b1100_1001;

    logic [13:0] exp_q[$];
    string       name_q[$];
    int          n_vec = 0;
    int          n_miss = 0;
    logic        stim_done = 1'b0;

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; m_rd = 0; wb_rd = 0;
        id_uses_rs2 = 0; id_branch = 0; pc_src = 0; ex_mem_read = 0; ex_muldiv = 0;
        ex_reg_write = 0; m_reg_write = 0; wb_reg_write = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string nm, input logic [7:0] ctl,
                            input logic [1:0] o1, input logic [1:0] o2, input logic [1:0] r0);
        exp_q.push_back({ctl, o1, o2, r0});
        name_q.push_back(nm);
    endtask

    // Monitor: one presented output set per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [13:0] exp_v, act_v;
            string       nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {pc_write, ifid_write, ifid_flush, ctrl_flush, idex_write, exm_bubble,
                     md_busy, md_done, op1_fwd, op2_fwd, r0_fwd};
            n_vec++;
            if (act_v !== exp_v) begin
                n_miss++;
                $display("FAIL %s: got %b required %b", nm, act_v, exp_v);
            end
        end
    end

    initial begin
        clr();
        // reset with hazard-provoking inputs
        tick();
        id_rs1 = 4'($urandom); ex_rd = id_rs1; m_rd = 4'($urandom); wb_rd = 4'($urandom);
        ex_reg_write = 2'b11; m_reg_write = 2'b11; wb_reg_write = 2'b11;
        ex_mem_read = 1; ex_muldiv = 1; pc_src = 1; id_branch = 1;
        expect_v("reset", NORM, 2'b00, 2'b00, 2'b00);
        tick(); reset_n = 1; clr();
        expect_v("reset_release", NORM, 2'b00, 2'b00, 2'b00);

        // forwarding priority
        tick(); id_rs1 = 3; ex_rd = 3; m_rd = 3; wb_rd = 3;
        ex_reg_write = 2'b01; m_reg_write = 2'b01; wb_reg_write = 2'b01;
        expect_v("fwd_ex", NORM, 2'b01, 2'b00, 2'b00);
        tick(); ex_reg_write = 2'b00;
        expect_v("fwd_m", NORM, 2'b10, 2'b00, 2'b00);
        tick(); ex_reg_write = 2'b01; ex_mem_read = 1;
        expect_v("fwd_load_rs1", HZ, 2'b10, 2'b00, 2'b00);
        tick(); clr(); id_rs1 = 3; wb_rd = 3; wb_reg_write = 2'b01;
        expect_v("fwd_wb", NORM, 2'b11, 2'b00, 2'b00);

        // load-use through rs2
        tick(); clr(); ex_mem_read = 1; ex_reg_write = 2'b01; ex_rd = 5;
        id_rs2 = 5; id_uses_rs2 = 1; id_rs1 = 1;
        expect_v("loaduse_rs2", HZ, 2'b00, 2'b00, 2'b00);
        tick(); pc_src = 1;
        expect_v("loaduse_flush_supp", HZ, 2'b00, 2'b00, 2'b00);
        tick(); id_uses_rs2 = 0;
        expect_v("rs2_unused_flush", FLSH, 2'b00, 2'b00, 2'b00);

        // branch flush
        tick(); clr(); pc_src = 1;
        expect_v("branch_flush", FLSH, 2'b00, 2'b00, 2'b00);
        tick(); clr();
        expect_v("flush_one_cycle", NORM, 2'b00, 2'b00, 2'b00);

        // branch-compare stall
        tick(); clr(); id_branch = 1; ex_reg_write = 2'b01; ex_rd = 7; id_rs1 = 7; pc_src = 1;
        expect_v("branch_cmp_stall", HZ, 2'b01, 2'b00, 2'b00);
        tick(); id_rs1 = 6;
        expect_v("branch_no_match", FLSH, 2'b00, 2'b00, 2'b00);

        // R0 forwarding
        tick(); clr(); m_reg_write = 2'b10; m_rd = 9; wb_reg_write = 2'b01; wb_rd = 0; id_rs2 = 4;
        expect_v("r0_m_over_wb", NORM, 2'b11, 2'b00, 2'b10);
        tick(); ex_reg_write = 2'b01; ex_rd = 0;
        expect_v("r0_ex_rd0", NORM, 2'b01, 2'b00, 2'b01);
        tick(); clr(); wb_reg_write = 2'b10; wb_rd = 5;
        expect_v("r0_wb_bit1", NORM, 2'b00, 2'b00, 2'b11);

        // mul/div, latency 4, forwarding kept valid, flush suppressed
        tick(); clr(); ex_muldiv = 1; m_rd = 3; m_reg_write = 2'b01; id_rs1 = 3; pc_src = 1;
        expect_v("md_stall1", MD, 2'b10, 2'b00, 2'b00);
        tick(); expect_v("md_stall2", MD, 2'b10, 2'b00, 2'b00);
        tick(); expect_v("md_stall3", MD, 2'b10, 2'b00, 2'b00);
        tick(); pc_src = 0;
        expect_v("md_done", DONE, 2'b10, 2'b00, 2'b00);
        tick(); expect_v("md2_stall1", MD, 2'b10, 2'b00, 2'b00);
        tick(); expect_v("md2_stall2", MD, 2'b10, 2'b00, 2'b00);
        tick(); expect_v("md2_stall3", MD, 2'b10, 2'b00, 2'b00);
        tick(); expect_v("md2_done", DONE, 2'b10, 2'b00, 2'b00);
        tick(); ex_muldiv = 0;
        expect_v("md_idle", NORM, 2'b10, 2'b00, 2'b00);

        // reset mid mul/div
        tick(); ex_muldiv = 1;
        expect_v("md3_stall1", MD, 2'b10, 2'b00, 2'b00);
        tick(); expect_v("md3_stall2", MD, 2'b10, 2'b00, 2'b00);
        tick(); reset_n = 0;
        expect_v("md_reset_abort", NORM, 2'b00, 2'b00, 2'b00);
        tick(); reset_n = 1; clr();
        expect_v("post_reset_no_done", NORM, 2'b00, 2'b00, 2'b00);
        tick(); expect_v("post_reset_idle", NORM, 2'b00, 2'b00, 2'b00);
        stim_done = 1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        repeat (3) @(posedge clk);
        if (!stim_done || exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: stim_done=%0d pending=%0d required 1/0", stim_done, exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
